// File: rtl/alu_txn_monitor_if.sv
// Bus between an ALU transaction source and the checker: sampled transaction in, verdicts out.
interface alu_txn_monitor_if #(
   parameter int unsigned CNT_W = 8
);
   logic             in_valid;
   logic [3:0]       in_a;
   logic [3:0]       in_b;
   logic [1:0]       in_op;
   logic [3:0]       dut_res;
   logic             dut_cout;
   logic             clear;
   logic             mism_pulse;
   logic [CNT_W-1:0] txn_count;
   logic [CNT_W-1:0] mism_count;
   logic             alarm;
   logic             snap_valid;
   logic [10:0]      snap_txn;
   logic [4:0]       snap_exp;
   logic [4:0]       snap_got;

   modport master (
      output in_valid, in_a, in_b, in_op, dut_res, dut_cout, clear,
      input  mism_pulse, txn_count, mism_count, alarm, snap_valid, snap_txn, snap_exp, snap_got
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, dut_res, dut_cout, clear,
      output mism_pulse, txn_count, mism_count, alarm, snap_valid, snap_txn, snap_exp, snap_got
   );
endinterface

// File: rtl/alu_txn_monitor.sv
// Golden-model checker for a 4-bit ADD/SUB/AND/OR ALU: counts, flags and snapshots mismatches.
module alu_txn_monitor #(
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned ALARM_THRESH = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_txn_monitor_if.slave   bus
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] Thresh = CNT_W'(ALARM_THRESH);

   typedef enum logic [0:0] {StMonitor, StLocked} state_e;

   state_e           state_q;
   logic             s1_valid_q;
   logic [3:0]       s1_a_q, s1_b_q, s1_res_q;
   logic [1:0]       s1_op_q;
   logic             s1_cout_q;
   logic [4:0]       golden;
   logic             mism;
   logic [CNT_W-1:0] txn_count_q, txn_count_d;
   logic [CNT_W-1:0] mism_count_q, mism_count_d;
   logic             mism_pulse_q, alarm_q, snap_valid_q;
   logic [10:0]      snap_txn_q;
   logic [4:0]       snap_exp_q, snap_got_q;

   // S1: clear flushes the slot so a transaction sampled alongside it is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= '0;
         s1_res_q   <= '0;
         s1_cout_q  <= 1'b0;
      end else begin
         s1_valid_q <= bus.in_valid & ~bus.clear;
         if (bus.in_valid && !bus.clear) begin
            s1_a_q    <= bus.in_a;
            s1_b_q    <= bus.in_b;
            s1_op_q   <= bus.in_op;
            s1_res_q  <= bus.dut_res;
            s1_cout_q <= bus.dut_cout;
         end
      end
   end

   always_comb begin
      golden = '0;
      unique case (s1_op_q)
         2'b00: golden = {1'b0, s1_a_q} + {1'b0, s1_b_q};
         2'b01: golden = {1'b0, s1_a_q} - {1'b0, s1_b_q};
         2'b10: golden = {1'b0, s1_a_q & s1_b_q};
         2'b11: golden = {1'b0, s1_a_q | s1_b_q};
         default: golden = '0;
      endcase
      mism = s1_valid_q && ({s1_cout_q, s1_res_q} != golden);

      txn_count_d = txn_count_q;
      if (s1_valid_q && (txn_count_q != CntMax)) begin
         txn_count_d = txn_count_q + CNT_W'(1);
      end
      mism_count_d = mism_count_q;
      if (mism && (mism_count_q != CntMax)) begin
         mism_count_d = mism_count_q + CNT_W'(1);
      end
   end

   // S2 results and snapshot FSM; clear outranks any mismatch on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StMonitor;
         mism_pulse_q <= 1'b0;
         txn_count_q  <= '0;
         mism_count_q <= '0;
         alarm_q      <= 1'b0;
         snap_valid_q <= 1'b0;
         snap_txn_q   <= '0;
         snap_exp_q   <= '0;
         snap_got_q   <= '0;
      end else if (bus.clear) begin
         state_q      <= StMonitor;
         mism_pulse_q <= 1'b0;
         txn_count_q  <= '0;
         mism_count_q <= '0;
         alarm_q      <= 1'b0;
         snap_valid_q <= 1'b0;
         snap_txn_q   <= '0;
         snap_exp_q   <= '0;
         snap_got_q   <= '0;
      end else begin
         mism_pulse_q <= mism;
         txn_count_q  <= txn_count_d;
         mism_count_q <= mism_count_d;
         if (mism_count_d >= Thresh) begin
            alarm_q <= 1'b1;
         end
         unique case (state_q)
            StMonitor: begin
               if (mism) begin
                  snap_txn_q   <= {s1_op_q, s1_b_q, s1_a_q, 1'b0};
                  snap_exp_q   <= golden;
                  snap_got_q   <= {s1_cout_q, s1_res_q};
                  snap_valid_q <= 1'b1;
                  state_q      <= StLocked;
               end
            end
            StLocked: state_q <= StLocked;
            default:  state_q <= StMonitor;
         endcase
      end
   end

   assign bus.mism_pulse = mism_pulse_q;
   assign bus.txn_count  = txn_count_q;
   assign bus.mism_count = mism_count_q;
   assign bus.alarm      = alarm_q;
   assign bus.snap_valid = snap_valid_q;
   assign bus.snap_txn   = snap_txn_q;
   assign bus.snap_exp   = snap_exp_q;
   assign bus.snap_got   = snap_got_q;

endmodule

// File: tb/tb_alu_txn_monitor.sv
// Scoreboard bench: directed vectors push hand-computed expectations, a monitor pops and compares.
module tb_alu_txn_monitor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_txn_monitor_if #(.CNT_W(8)) m1 ();
   alu_txn_monitor_if #(.CNT_W(2)) m2 ();

   alu_txn_monitor #(.CNT_W(8), .ALARM_THRESH(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(m1));
   alu_txn_monitor #(.CNT_W(2), .ALARM_THRESH(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(m2));

   typedef struct {
      bit          sel;
      int          due;
      logic        pulse;
      logic [7:0]  txn;
      logic [7:0]  mism;
      logic        alarm;
      logic        sv;
      logic [10:0] st;
      logic [4:0]  se;
      logic [4:0]  sg;
   } item_t;

   item_t q[$];

   // Expected snapshot contents, set by the stimulus before the capturing transaction.
   logic [10:0] exp_st;
   logic [4:0]  exp_se, exp_sg;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   task automatic step(input bit sel, input bit v, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, input logic [4:0] got, input bit clr,
                       input bit ep, input int et, input int em, input bit eal, input bit esv);
      item_t it;
      m1.in_valid = v & ~sel;
      m2.in_valid = v & sel;
      m1.clear    = clr & ~sel;
      m2.clear    = clr & sel;
      m1.in_a = a;  m1.in_b = b;  m1.in_op = op;  m1.dut_res = got[3:0];  m1.dut_cout = got[4];
      m2.in_a = a;  m2.in_b = b;  m2.in_op = op;  m2.dut_res = got[3:0];  m2.dut_cout = got[4];
      it.sel   = sel;
      it.due   = cyc + 2;
      it.pulse = ep;
      it.txn   = 8'(et);
      it.mism  = 8'(em);
      it.alarm = eal;
      it.sv    = esv;
      it.st    = esv ? exp_st : 11'd0;
      it.se    = esv ? exp_se : 5'd0;
      it.sg    = esv ? exp_sg : 5'd0;
      q.push_back(it);
      @(negedge clk);
   endtask

   task automatic idle(input bit sel, input bit ep, input int et, input int em, input bit eal,
                       input bit esv);
      step(sel, 1'b0, 4'd0, 4'd0, 2'd0, 5'd0, 1'b0, ep, et, em, eal, esv);
   endtask

   // Monitor: compares every output field once the entry's due cycle is reached.
   initial begin
      item_t it;
      forever begin
         @(posedge clk);
         #1;
         while (q.size() > 0 && q[0].due <= cyc) begin
            it = q.pop_front();
            if (it.due < cyc) begin
               chk("stale_entry", 32'(cyc), 32'(it.due));
            end else if (!it.sel) begin
               chk("d1_pulse", 32'(m1.mism_pulse), 32'(it.pulse));
               chk("d1_txn", 32'(m1.txn_count), 32'(it.txn));
               chk("d1_mism", 32'(m1.mism_count), 32'(it.mism));
               chk("d1_alarm", 32'(m1.alarm), 32'(it.alarm));
               chk("d1_snap_valid", 32'(m1.snap_valid), 32'(it.sv));
               chk("d1_snap_txn", 32'(m1.snap_txn), 32'(it.st));
               chk("d1_snap_exp", 32'(m1.snap_exp), 32'(it.se));
               chk("d1_snap_got", 32'(m1.snap_got), 32'(it.sg));
            end else begin
               chk("d2_pulse", 32'(m2.mism_pulse), 32'(it.pulse));
               chk("d2_txn", 32'(m2.txn_count), 32'(it.txn));
               chk("d2_mism", 32'(m2.mism_count), 32'(it.mism));
               chk("d2_alarm", 32'(m2.alarm), 32'(it.alarm));
               chk("d2_snap_valid", 32'(m2.snap_valid), 32'(it.sv));
               chk("d2_snap_txn", 32'(m2.snap_txn), 32'(it.st));
               chk("d2_snap_exp", 32'(m2.snap_exp), 32'(it.se));
               chk("d2_snap_got", 32'(m2.snap_got), 32'(it.sg));
            end
         end
      end
   end

   initial begin
      m1.in_valid = 1'b0; m1.clear = 1'b0; m1.in_a = '0; m1.in_b = '0; m1.in_op = '0;
      m1.dut_res = '0; m1.dut_cout = 1'b0;
      m2.in_valid = 1'b0; m2.clear = 1'b0; m2.in_a = '0; m2.in_b = '0; m2.in_op = '0;
      m2.dut_res = '0; m2.dut_cout = 1'b0;
      exp_st = '0; exp_se = '0; exp_sg = '0;
      repeat (2) @(negedge clk);
      chk("reset_pulse", 32'(m1.mism_pulse), 32'd0);
      chk("reset_txn", 32'(m1.txn_count), 32'd0);
      chk("reset_snap_valid", 32'(m1.snap_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      //        sel v  a      b      op     got        clr  ep txn mism al sv
      idle(0,                                                0, 0,  0,  0, 0);
      step(0, 1, 4'd5,  4'd3,  2'b00, 5'b01000, 0,           0, 1,  0,  0, 0);
      idle(0,                                                0, 1,  0,  0, 0);
      step(0, 1, 4'd3,  4'd5,  2'b01, 5'b11110, 0,           0, 2,  0,  0, 0);
      step(0, 1, 4'd5,  4'd3,  2'b01, 5'b00010, 0,           0, 3,  0,  0, 0);
      exp_st = 11'b00_1111_1111_0; exp_se = 5'b11110; exp_sg = 5'b01111;
      step(0, 1, 4'd15, 4'd15, 2'b00, 5'b01111, 0,           1, 4,  1,  0, 1);
      step(0, 1, 4'd9,  4'd6,  2'b00, 5'b10101, 0,           1, 5,  2,  0, 1);
      step(0, 1, 4'd3,  4'd12, 2'b11, 5'b11111, 0,           1, 6,  3,  1, 1);
      step(0, 1, 4'd12, 4'd10, 2'b10, 5'b01000, 0,           0, 7,  3,  1, 1);
      // Mismatch reaches S2 on the same edge as clear; the clear-cycle transaction is dropped.
      step(0, 1, 4'd1,  4'd1,  2'b00, 5'b00011, 0,           0, 0,  0,  0, 0);
      step(0, 1, 4'd2,  4'd2,  2'b00, 5'b00000, 1,           0, 0,  0,  0, 0);
      idle(0,                                                0, 0,  0,  0, 0);
      step(0, 1, 4'd2,  4'd2,  2'b00, 5'b00100, 0,           0, 1,  0,  0, 0);
      exp_st = 11'b10_0011_0110_0; exp_se = 5'b00010; exp_sg = 5'b10010;
      step(0, 1, 4'd6,  4'd3,  2'b10, 5'b10010, 0,           1, 2,  1,  0, 1);
      idle(0,                                                0, 2,  1,  0, 1);

      // Narrow counters saturate at 3.
      exp_st = 11'd0; exp_se = 5'b00000; exp_sg = 5'b00001;
      step(1, 1, 4'd0,  4'd0,  2'b00, 5'b00001, 0,           1, 1,  1,  0, 1);
      step(1, 1, 4'd0,  4'd0,  2'b00, 5'b00001, 0,           1, 2,  2,  0, 1);
      step(1, 1, 4'd0,  4'd0,  2'b00, 5'b00001, 0,           1, 3,  3,  1, 1);
      step(1, 1, 4'd0,  4'd0,  2'b00, 5'b00001, 0,           1, 3,  3,  1, 1);
      step(1, 1, 4'd0,  4'd0,  2'b00, 5'b00001, 0,           1, 3,  3,  1, 1);
      idle(1,                                                0, 3,  3,  1, 1);
      idle(1,                                                0, 3,  3,  1, 1);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         n_checks++;
         n_err++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
